receive: RTL and testbench

- UART-style serial receiver; the receive-side counterpart of the team's transmit block.
- Accepts 8N1 frames on rxd, one start bit (0), 8 data bits LSB first, one stop bit (1).
- Uses a tick from the shared baud generator at OVERSAMPLE ticks per bit and samples each bit at mid-bit.
- Presents the completed byte to the bus interface with a ready flag that is cleared on read.

---
 rtl/receive.sv | 165 ++++++++++++++++
 tb/tb_receive.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receive.sv
// rtl/receive.sv - 8N1 serial receiver with mid-bit oversampling; framing-error reporting enabled by RECEIVE_FERR_EN
module receive #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       receive_baud,
  input  logic       rxd,
  input  logic       receive_read_en,
  output logic [7:0] receive_read_line,
  output logic       rda,
  output logic       overrun
`ifdef RECEIVE_FERR_EN
  ,
  output logic       ferr
`endif
);

  localparam logic [CNT_W-1:0] TICK_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q;
  logic             rxd_meta_q;
  logic             rxd_s_q;
  logic [CNT_W-1:0] tick_cnt_q;
  logic [CNT_W-1:0] tick_cnt_d;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic [7:0]       shift_d;
  logic [7:0]       line_q;
  logic             rda_q;
  logic             overrun_q;
  logic             overrun_d;
  logic             accept_d;
`ifdef RECEIVE_FERR_EN
  logic             ferr_q;
`endif

  // Next-value helpers: LSB arrives first, so new bits enter at the top and move right.
  assign tick_cnt_d = tick_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  assign shift_d    = {rxd_s_q, shift_q[7:1]};
  // A completion while unread data is pending is an overrun, unless the consumer reads in the same cycle.
  assign overrun_d  = (overrun_q | rda_q) & ~receive_read_en;

`ifdef RECEIVE_FERR_EN
  // Frames with a bad stop bit are still delivered; ferr flags them.
  assign accept_d = 1'b1;
`else
  // Frames with a bad stop bit are dropped without touching the outputs.
  assign accept_d = rxd_s_q;
`endif

  // Two-flop synchronizer for the asynchronous line; idles high so reset looks like a quiet line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_s_q    <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_s_q    <= rxd_meta_q;
    end
  end

  // Frame FSM with registered outputs; counters only advance on baud ticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= 8'h00;
      line_q     <= 8'h00;
      rda_q      <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef RECEIVE_FERR_EN
      ferr_q     <= 1'b0;
`endif
    end else begin
      // A read clears the status flags; a completion below in the same cycle overrides.
      if (receive_read_en) begin
        rda_q     <= 1'b0;
        overrun_q <= 1'b0;
`ifdef RECEIVE_FERR_EN
        ferr_q    <= 1'b0;
`endif
      end

      if (receive_baud) begin
        case (state_q)
          IDLE: begin
            if (!rxd_s_q) begin
              state_q    <= START;
              tick_cnt_q <= '0;
            end
          end

          START: begin
            if (tick_cnt_q == TICK_MID) begin
              tick_cnt_q <= '0;
              if (rxd_s_q) begin
                // Line went back high before mid start bit: treat as noise.
                state_q <= IDLE;
              end else begin
                state_q   <= DATA;
                bit_cnt_q <= '0;
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end

          DATA: begin
            if (tick_cnt_q == TICK_LAST) begin
              tick_cnt_q <= '0;
              shift_q    <= shift_d;
              bit_cnt_q  <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                state_q <= STOP;
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end

          STOP: begin
            if (tick_cnt_q == TICK_LAST) begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              tick_cnt_q <= '0;
              state_q    <= IDLE;
              if (accept_d) begin
                line_q    <= shift_q;
                rda_q     <= 1'b1;
                overrun_q <= overrun_d;
`ifdef RECEIVE_FERR_EN
                ferr_q    <= ~rxd_s_q;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_d;
            end
          end

          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign receive_read_line = line_q;
  assign rda               = rda_q;
  assign overrun           = overrun_q;
`ifdef RECEIVE_FERR_EN
  assign ferr              = ferr_q;
`endif

endmodule

// File: tb/tb_receive.sv
// tb/tb_receive.sv - scoreboard bench for the 8N1 receiver
module tb_receive;

  localparam int OVERSAMPLE = 16;
  localparam int BAUD_DIV   = 4;
  localparam int BIT_CLK    = OVERSAMPLE * BAUD_DIV;

  logic       clk;
  logic       rst;
  logic       receive_baud;
  logic       rxd;
  logic       receive_read_en;
  logic [7:0] receive_read_line;
  logic       rda;
  logic       overrun;
`ifdef RECEIVE_FERR_EN
  logic       ferr;
`endif

  typedef struct {
    logic [7:0] data;
    logic       ovr;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  int   total;
  int   bad;

  receive #(.OVERSAMPLE(OVERSAMPLE), .CNT_W(6)) dut (
    .clk               (clk),
    .rst               (rst),
    .receive_baud      (receive_baud),
    .rxd               (rxd),
    .receive_read_en   (receive_read_en),
    .receive_read_line (receive_read_line),
    .rda               (rda),
    .overrun           (overrun)
`ifdef RECEIVE_FERR_EN
    ,
    .ferr              (ferr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud tick: one clk high every BAUD_DIV clks, changed away from the active edge.
  initial begin
    int cnt;
    cnt = 0;
    receive_baud = 1'b0;
    forever begin
      @(negedge clk);
      receive_baud = (cnt == BAUD_DIV - 1);
      cnt = (cnt + 1) % BAUD_DIV;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", exp_q.size());
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: an output event is a new byte presented (rda rising, data replaced, or overrun rising).
  initial begin
    logic       prev_rda;
    logic [7:0] prev_line;
    logic       prev_ovr;
    exp_t       e;
    prev_rda  = 1'b0;
    prev_line = 8'h00;
    prev_ovr  = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && rda && (!prev_rda || receive_read_line != prev_line || (overrun && !prev_ovr))) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL mon_unexpected: got byte %0h with no expectation queued", receive_read_line);
        end else begin
          e = exp_q.pop_front();
          check("mon_data", {24'h0, receive_read_line}, {24'h0, e.data});
          check("mon_overrun", {31'h0, overrun}, {31'h0, e.ovr});
`ifdef RECEIVE_FERR_EN
          check("mon_ferr", {31'h0, ferr}, {31'h0, e.fe});
`endif
        end
      end
      prev_rda  = rda;
      prev_line = receive_read_line;
      prev_ovr  = overrun;
    end
  end

  task automatic expect_byte(input logic [7:0] d, input logic ovr, input logic fe);
    exp_t e;
    e.data = d;
    e.ovr  = ovr;
    e.fe   = fe;
    exp_q.push_back(e);
  endtask

  // Bits are sent LSB first: bits[0] goes out first.
  task automatic send_bits(input logic [9:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    send_bits({stop_bit, b, 1'b0}, 10);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  task automatic do_read;
    @(negedge clk);
    receive_read_en = 1'b1;
    @(negedge clk);
    receive_read_en = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    rxd = 1'b1;
    receive_read_en = 1'b0;

    // Reset state
    do_reset();
    check("reset_rda", {31'h0, rda}, 0);
    check("reset_overrun", {31'h0, overrun}, 0);
    check("reset_data", {24'h0, receive_read_line}, 32'h00);
`ifdef RECEIVE_FERR_EN
    check("reset_ferr", {31'h0, ferr}, 0);
`endif
    repeat (BIT_CLK) @(negedge clk);
    check("idle_rda", {31'h0, rda}, 0);

    // Good frame and read
    expect_byte(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1);
    wait_drain("drain_a5");
    do_read();
    check("read_clears_rda", {31'h0, rda}, 0);
    check("read_holds_data", {24'h0, receive_read_line}, 32'hA5);
    do_read();
    check("read_idle_rda", {31'h0, rda}, 0);
    check("read_idle_data", {24'h0, receive_read_line}, 32'hA5);

    // Glitch shorter than half a bit, then a real frame
    rxd = 1'b0;
    repeat (3 * BAUD_DIV) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * BIT_CLK) @(negedge clk);
    check("glitch_rda", {31'h0, rda}, 0);
    check("glitch_data", {24'h0, receive_read_line}, 32'hA5);
    expect_byte(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1);
    wait_drain("drain_3c");
    do_read();
    check("read_3c_rda", {31'h0, rda}, 0);

    // Overrun: two frames, no read in between
    expect_byte(8'h11, 1'b0, 1'b0);
    send_frame(8'h11, 1'b1);
    repeat (BIT_CLK) @(negedge clk);
    expect_byte(8'h22, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    wait_drain("drain_ovr");
    check("ovr_set", {31'h0, overrun}, 1);
    check("ovr_rda", {31'h0, rda}, 1);
    check("ovr_data", {24'h0, receive_read_line}, 32'h22);
    do_read();
    check("ovr_read_rda", {31'h0, rda}, 0);
    check("ovr_read_clear", {31'h0, overrun}, 0);

    // Bad stop bit
`ifdef RECEIVE_FERR_EN
    expect_byte(8'h5A, 1'b0, 1'b1);
    send_frame(8'h5A, 1'b0);
    wait_drain("drain_5a");
    repeat (2 * BIT_CLK) @(negedge clk);
    check("ferr_set", {31'h0, ferr}, 1);
    check("ferr_rda", {31'h0, rda}, 1);
    check("ferr_data", {24'h0, receive_read_line}, 32'h5A);
    do_read();
    check("ferr_read_clear", {31'h0, ferr}, 0);
`else
    send_frame(8'h5A, 1'b0);
    repeat (2 * BIT_CLK) @(negedge clk);
    check("badstop_rda", {31'h0, rda}, 0);
    check("badstop_data", {24'h0, receive_read_line}, 32'h22);
    check("badstop_overrun", {31'h0, overrun}, 0);
`endif

    // Reset after start + 4 data bits
    send_bits({1'b1, 8'hC3, 1'b0}, 5);
    do_reset();
    repeat (2 * BIT_CLK) @(negedge clk);
    check("midrst_rda", {31'h0, rda}, 0);
    check("midrst_data", {24'h0, receive_read_line}, 32'h00);
    check("midrst_overrun", {31'h0, overrun}, 0);
    expect_byte(8'hFF, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b1);
    wait_drain("drain_ff");
    do_read();

    // Back-to-back frames with zero idle gap; second completes while the first is unread
    expect_byte(8'h00, 1'b0, 1'b0);
    expect_byte(8'h80, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1);
    send_frame(8'h80, 1'b1);
    wait_drain("drain_b2b");
    check("b2b_data", {24'h0, receive_read_line}, 32'h80);
    do_read();
    check("b2b_read_rda", {31'h0, rda}, 0);
    check("b2b_read_overrun", {31'h0, overrun}, 0);

    repeat (10) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
